// File: rtl/round_key_sequencer.sv
// -----------------------------------------------------------------------------
// round_key_sequencer
//
// Steps the AES-256 round-key ROM address (selectKey) through the 15 round
// keys of one block operation and offers each key to the AddRoundKey datapath
// over a valid/ack handshake. Flags the first and last key, pulses done after
// the last key is consumed, supports abort, and records a sticky error when a
// start arrives while a sequence is already running.
//
// Handshake: while rk_valid=1, selectKey (and the combinational ROM data it
// addresses) is stable; a key is consumed on a rising edge where
// rk_valid=1 and rk_ack=1. rk_ack is ignored while rk_valid=0. There is no
// timeout: without rk_ack the current key is held indefinitely.
//
// Optional feature macro: ROUND_KEY_SEQ_DECRYPT_EN
//   defined   : decrypt is sampled on an accepted start; decrypt sequences
//               run NUM_ROUNDS down to 0.
//   undefined : decrypt is ignored and every sequence ascends 0..NUM_ROUNDS.
//
// Ports
//   clk         in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   start       in   request a new sequence (accepted only in IDLE)
//   decrypt     in   direction, sampled on accepted start
//   abort       in   cancel a sequence in ISSUE/DONE
//   rk_ack      in   datapath consumed the current key
//   selectKey   out  registered ROM key-select address
//   rk_valid    out  current key valid for the datapath
//   rk_first    out  current key is the first of the sequence
//   rk_last     out  current key is the last of the sequence
//   round_cnt   out  keys acknowledged in the current sequence
//   busy        out  not IDLE
//   done        out  one-cycle pulse after last key acknowledged
//   err         out  sticky start-while-busy flag
//   dbg_state_o out  current FSM state (IDLE=0, ISSUE=1, DONE=2)
// -----------------------------------------------------------------------------
module round_key_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_ROUNDS = 14
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  decrypt,
  input  logic                  abort,
  input  logic                  rk_ack,
  output logic [ADDR_WIDTH-1:0] selectKey,
  output logic                  rk_valid,
  output logic                  rk_first,
  output logic                  rk_last,
  output logic [ADDR_WIDTH-1:0] round_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_KEY = ADDR_WIDTH'(NUM_ROUNDS);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ZERO     = '0;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;

  // Output flags are registered from next-state values so they line up with
  // state_q/cnt_q without any input-to-output combinational path.
  logic                  valid_q, valid_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next key address for an acknowledged, non-final key.
  logic [ADDR_WIDTH-1:0] sel_step;

`ifdef ROUND_KEY_SEQ_DECRYPT_EN
  logic dec_q, dec_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dec_q <= 1'b0;
    end else begin
      dec_q <= dec_d;
    end
  end

  always_comb begin
    dec_d = dec_q;
    if (state_q == S_IDLE && start) begin
      dec_d = decrypt;
    end
  end

  // The final key never steps, so a descending run stops at 0 and an
  // ascending run stops at NUM_ROUNDS with no wrap.
  assign sel_step = dec_q ? (sel_q - ONE) : (sel_q + ONE);
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
  assign sel_step       = sel_q + ONE;
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      sel_q   <= ZERO;
      cnt_q   <= ZERO;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: abort > rk_ack > start.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        // abort has no meaning here; a simultaneous start is still accepted.
        if (start) begin
          state_d = S_ISSUE;
          cnt_d   = ZERO;
          err_d   = 1'b0;
`ifdef ROUND_KEY_SEQ_DECRYPT_EN
          sel_d   = decrypt ? LAST_KEY : ZERO;
`else
          sel_d   = ZERO;
`endif
        end
      end

      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
          sel_d   = ZERO;
          cnt_d   = ZERO;
        end else if (rk_ack) begin
          // On the final key the count reaches NUM_ROUNDS+1 and the address
          // is left on the last key.
          cnt_d = cnt_q + ONE;
          if (cnt_q == LAST_KEY) begin
            state_d = S_DONE;
          end else begin
            sel_d = sel_step;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (abort) begin
          sel_d = ZERO;
          cnt_d = ZERO;
        end
      end

      default: begin
        state_d = S_IDLE;
        sel_d   = ZERO;
        cnt_d   = ZERO;
      end
    endcase

    // A start while busy is dropped but remembered.
    if (start && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered output flags derived from the upcoming state.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d = (state_d == S_ISSUE);
    first_d = (state_d == S_ISSUE) && (cnt_d == ZERO);
    last_d  = (state_d == S_ISSUE) && (cnt_d == LAST_KEY);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  assign selectKey   = sel_q;
  assign round_cnt   = cnt_q;
  assign rk_valid    = valid_q;
  assign rk_first    = first_q;
  assign rk_last     = last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_round_key_sequencer.sv
// -----------------------------------------------------------------------------
// tb_round_key_sequencer
//
// Reference model describes a sequence by how many keys have been consumed
// and its direction; expected address and flags follow from that count.
// Directed scenarios check literal key orders, timing and flag behaviour;
// a randomized phase exercises start/abort/ack/decrypt interleavings.
// -----------------------------------------------------------------------------
module tb_round_key_sequencer;

  localparam int AW = 4;
  localparam int NR = 14;

`ifdef ROUND_KEY_SEQ_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic          start, decrypt, abort, rk_ack;
  logic [AW-1:0] selectKey, round_cnt;
  logic          rk_valid, rk_first, rk_last, busy, done, err;
  logic [1:0]    dbg_state;

  round_key_sequencer #(.ADDR_WIDTH(AW), .NUM_ROUNDS(NR)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .decrypt    (decrypt),
    .abort      (abort),
    .rk_ack     (rk_ack),
    .selectKey  (selectKey),
    .rk_valid   (rk_valid),
    .rk_first   (rk_first),
    .rk_last    (rk_last),
    .round_cnt  (round_cnt),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a sequence is "running" with m_acked keys consumed,
  // or in its one-cycle finished window, or idle.
  // ---------------------------------------------------------------------------
  bit m_run  = 1'b0;
  bit m_fin  = 1'b0;
  bit m_desc = 1'b0;
  bit m_err  = 1'b0;
  int m_acked = 0;
  int m_sel   = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_run <= 1'b0; m_fin <= 1'b0; m_desc <= 1'b0; m_err <= 1'b0;
      m_acked <= 0;  m_sel <= 0;
    end else begin
      if (start && (m_run || m_fin)) m_err <= 1'b1;
      if (m_run) begin
        if (abort) begin
          m_run <= 1'b0; m_acked <= 0; m_sel <= 0;
        end else if (rk_ack) begin
          m_acked <= m_acked + 1;
          if (m_acked == NR) begin
            m_run <= 1'b0; m_fin <= 1'b1;
          end else begin
            m_sel <= m_desc ? (NR - (m_acked + 1)) : (m_acked + 1);
          end
        end
      end else if (m_fin) begin
        m_fin <= 1'b0;
        if (abort) begin m_acked <= 0; m_sel <= 0; end
      end else if (start) begin
        m_run   <= 1'b1;
        m_acked <= 0;
        m_err   <= 1'b0;
        m_desc  <= DEC_EN && decrypt;
        m_sel   <= (DEC_EN && decrypt) ? NR : 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_sel",   32'(selectKey), 32'(m_sel));
      chk("m_cnt",   32'(round_cnt), 32'(m_acked));
      chk("m_valid", 32'(rk_valid),  32'(m_run));
      chk("m_first", 32'(rk_first),  32'(m_run && m_acked == 0));
      chk("m_last",  32'(rk_last),   32'(m_run && m_acked == NR));
      chk("m_busy",  32'(busy),      32'(m_run || m_fin));
      chk("m_done",  32'(done),      32'(m_fin));
      chk("m_err",   32'(err),       32'(m_err));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  logic [AW-1:0] exp_q[$];

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_valid"}, 32'(rk_valid), 0);
    chk({tag, "_sel"},   32'(selectKey), 0);
    chk({tag, "_cnt"},   32'(round_cnt), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
  endtask

  // Runs one full sequence; rk_ack is raised on every period-th ISSUE cycle.
  task automatic run_seq(input bit dec, input int period);
    int  c, acks, firsts, lasts, done_at;
    bit  d_eff;
    d_eff = DEC_EN && dec;
    tick; start = 1'b1; decrypt = dec; rk_ack = 1'b0; abort = 1'b0;
    tick; start = 1'b0;
    exp_q.delete();
    for (int k = 0; k <= NR; k++) exp_q.push_back(d_eff ? AW'(NR - k) : AW'(k));
    c = 0; acks = 0; firsts = 0; lasts = 0; done_at = -1;
    while (c < 200 && done_at < 0) begin
      if (done) begin
        done_at = c;
        rk_ack  = 1'b0;
      end else begin
        if (rk_valid) begin
          if (exp_q.size() == 0) chk("seq_extra_key", 1, 0);
          else chk("seq_key", 32'(selectKey), 32'(exp_q[0]));
          chk("seq_cnt", 32'(round_cnt), 32'(acks));
          firsts += int'(rk_first);
          lasts  += int'(rk_last);
          rk_ack = ((c % period) == (period - 1));
          if (rk_ack) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            acks++;
          end
        end else begin
          chk("seq_valid_drop", 32'(rk_valid), 1);
          rk_ack = 1'b0;
        end
        c++;
        tick;
      end
    end
    chk("seq_timeout", 32'(done_at >= 0), 1);
    chk("seq_issue_cycles", 32'(done_at), 32'(15 * period));
    chk("seq_keys_left", 32'(exp_q.size()), 0);
    chk("seq_first_cycles", 32'(firsts), 32'(period));
    chk("seq_last_cycles", 32'(lasts), 32'(period));
    chk("seq_done_cnt", 32'(round_cnt), 15);
    chk("seq_done_sel", 32'(selectKey), d_eff ? 0 : 14);
    chk("seq_done_valid", 32'(rk_valid), 0);
    tick;
    chk("seq_post_done", 32'(done), 0);
    chk("seq_post_busy", 32'(busy), 0);
    chk("seq_hold_sel", 32'(selectKey), d_eff ? 0 : 14);
    chk("seq_hold_cnt", 32'(round_cnt), 15);
  endtask

  // Starts an ascending sequence with rk_ack high and waits for key k.
  task automatic run_to_key(input int k, input string tag);
    int n;
    tick; start = 1'b1; decrypt = 1'b0; rk_ack = 1'b0;
    tick; start = 1'b0; rk_ack = 1'b1;
    n = 0;
    while (selectKey != AW'(k) && n < 40) begin tick; n++; end
    chk({tag, "_reach"}, 32'(selectKey), 32'(k));
  endtask

  // ---------------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    resetn = 1'b1; start = 1'b0; decrypt = 1'b0; abort = 1'b0; rk_ack = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check_idle_zero("rst");
    chk("rst_err", 32'(err), 0);
    chk("rst_first", 32'(rk_first), 0);
    chk("rst_last", 32'(rk_last), 0);
    tick; tick;
    resetn = 1'b1;
    cmp_en = 1'b1;

    run_seq(1'b0, 1);
    run_seq(1'b1, 1);
    run_seq(1'b0, 3);

    // Abort at key 7 (rk_ack also high: abort wins).
    run_to_key(7, "abort");
    abort = 1'b1;
    tick; abort = 1'b0; rk_ack = 1'b0;
    check_idle_zero("abort");
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("abort_no_done", 32'(done), 0);
    end

    // start while busy at key 5.
    run_to_key(5, "err");
    start = 1'b1;
    tick; start = 1'b0;
    chk("err_set", 32'(err), 1);
    chk("err_seq_continues", 32'(selectKey), 6);
    n = 0;
    while (!done && n < 40) begin tick; n++; end
    chk("err_done_seen", 32'(done), 1);
    chk("err_final_sel", 32'(selectKey), 14);
    chk("err_still_set", 32'(err), 1);
    rk_ack = 1'b0;
    tick;
    start = 1'b1; decrypt = 1'b0;
    tick; start = 1'b0;
    chk("err_cleared", 32'(err), 0);
    chk("err_restart_sel", 32'(selectKey), 0);
    chk("err_restart_valid", 32'(rk_valid), 1);
    abort = 1'b1;
    tick; abort = 1'b0;

    // Asynchronous reset at key 9.
    run_to_key(9, "arst");
    #1 resetn = 1'b0;
    #1;
    check_idle_zero("arst");
    chk("arst_err", 32'(err), 0);
    chk("arst_first", 32'(rk_first), 0);
    chk("arst_last", 32'(rk_last), 0);
    rk_ack = 1'b0;
    tick;
    resetn = 1'b1;
    tick; start = 1'b1;
    tick; start = 1'b0;
    chk("arst_restart_sel", 32'(selectKey), 0);
    chk("arst_restart_first", 32'(rk_first), 1);

    // Randomized interleavings, checked by the compare process.
    for (int i = 0; i < 4000; i++) begin
      tick;
      start   = ($urandom_range(0, 7) == 0);
      decrypt = $urandom_range(0, 1) == 1;
      abort   = ($urandom_range(0, 40) == 0);
      rk_ack  = ($urandom_range(0, 3) != 0);
    end
    start = 1'b0; abort = 1'b0; rk_ack = 1'b0;
    tick; tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
